audio_packet_rx: RTL and testbench
==================================

AUDIO_PACKET_RX -- requirements
Module: audio_packet_rx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: packet start marker.
REQ-002 SHALL have parameter CMD_AUDIO, default 8'h01: audio command code, excluding bit 7.
REQ-003 SHALL have port clk_i, input, 1: single clock (clk_24576000 domain); reset is synchronous and active-high.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rd_in_fifo_clk_o, output, 1: driven equal to clk_i.
REQ-006 SHALL have port rd_in_fifo_en_o, output, 1: read strobe to the input async FIFO.
REQ-007 SHALL have port rd_in_fifo_empty_i, input, 1: input FIFO empty flag.
REQ-008 SHALL have port rd_in_fifo_data_i, input, 8: FIFO read data, valid the cycle after rd_in_fifo_en_o.
REQ-009 SHALL have port sample_valid_o, output, 1: a stereo frame is presented.
REQ-010 SHALL have port sample_ready_i, input, 1: the consumer accepts the frame.
REQ-011 SHALL have port sample_left_o, output, 24: left sample, two's complement.
REQ-012 SHALL have port sample_right_o, output, 24: right sample, two's complement.
REQ-013 SHALL have port rate_48k_o, output, 1: 1 = 48 kHz family, 0 = 44.1 kHz family.
REQ-014 SHALL have port pkt_err_o, output, 1: one-cycle pulse on a framing error.
REQ-015 SHALL have port err_count_o, output, 8: count of framing errors, saturating.

Function
REQ-016 Packet format SHALL be: SYNC_BYTE, CMD, LEN, then LEN frames of 6 bytes each (L[7:0], L[15:8], L[23:16], R[7:0], R[15:8], R[23:16]).
REQ-017 CMD[6:0] SHALL equal CMD_AUDIO; CMD[7] SHALL give the rate family; LEN SHALL be in the range 1..255.
REQ-018 Read handshake: rd_in_fifo_en_o SHALL be a single-cycle pulse, asserted only when rd_in_fifo_empty_i=0, with at most one read outstanding.
REQ-019 Read handshake: the byte SHALL be captured on the following cycle, giving throughput of at most 1 byte per 2 clocks.
REQ-020 The FSM SHALL have the states SYNC, CMD, LEN, DATA and OUT, each of which waits for a byte capture except OUT.
REQ-021 SYNC: a byte equal to SYNC_BYTE SHALL move the FSM to CMD; any other byte SHALL be discarded silently, with no error.
REQ-022 CMD: on a valid code, the FSM SHALL latch CMD[7] into a pending-rate register and move to LEN; otherwise it SHALL pulse pkt_err_o and return to SYNC.
REQ-023 LEN: if LEN=0 the FSM SHALL pulse pkt_err_o and return to SYNC; otherwise it SHALL load the 8-bit frame counter and a byte index of 0, then move to DATA.
REQ-024 DATA: each byte SHALL go into a shift/assembly register at the byte index; on the 6th byte the FSM SHALL move to OUT.
REQ-025 OUT: the FSM SHALL update sample_left_o, sample_right_o and rate_48k_o (from pending-rate), and assert sample_valid_o on the first OUT cycle.
REQ-026 OUT: outputs SHALL hold stable while sample_valid_o=1 and sample_ready_i=0.
REQ-027 OUT: no FIFO reads SHALL occur in OUT.
REQ-028 On the cycle sample_valid_o=1 and sample_ready_i=1, sample_valid_o SHALL deassert next cycle and the frame counter SHALL decrement.
REQ-029 After acceptance, the FSM SHALL go to DATA if the counter is nonzero, otherwise to SYNC.
REQ-030 Handshake latency: the first OUT cycle SHALL follow the 6th-byte capture cycle by exactly 1 clock.
REQ-031 rate_48k_o SHALL change only on OUT entry, never mid-frame.
REQ-032 err_count_o SHALL increment on each pkt_err_o pulse and saturate at 8'hFF, with no wrap.
REQ-033 An empty FIFO mid-packet SHALL stall in the current state indefinitely, with no timeout and no error.
REQ-034 sample_ready_i asserted while sample_valid_o=0 SHALL be ignored.

Reset
REQ-035 While reset_i=1 at a clk_i edge, the FSM SHALL go to SYNC.
REQ-036 While reset_i=1, rd_in_fifo_en_o SHALL be 0, sample_valid_o SHALL be 0, and pkt_err_o SHALL be 0.
REQ-037 While reset_i=1, sample_left_o, sample_right_o, rate_48k_o, err_count_o, the frame counter and the byte index SHALL all be 0.
REQ-038 Reset asserted mid-packet or mid-OUT SHALL discard the partial frame, and any byte read but not yet captured SHALL be dropped.
REQ-039 rd_in_fifo_en_o SHALL NOT assert in the cycle that reset_i deasserts; the first read SHALL occur 1 cycle later at the earliest.

Verification
REQ-040 Stream A5 81 02 + frames (01 02 03 04 05 06), (FF FF 7F 00 00 80) with ready=1 SHALL produce 2 valid frames, L=030201 R=060504, then L=7FFFFF R=800000, with rate_48k_o=1 and err_count_o=0.
REQ-041 Bytes 00 13 A5 01 01 + 6 bytes SHALL resync silently to 1 frame with rate_48k_o=0 and no pkt_err_o.
REQ-042 A5 02 and A5 01 00 SHALL each pulse pkt_err_o once, with err_count_o=2 and no sample_valid_o.
REQ-043 sample_ready_i held at 0 for 20 cycles SHALL keep valid and data stable with rd_in_fifo_en_o=0 throughout, and the frame SHALL be accepted on the 1st cycle ready=1.
REQ-044 reset_i pulsed after the 3rd data byte, then a full packet, SHALL output only the new packet's frames with err_count_o=0.
REQ-045 300 bad-CMD packets SHALL leave err_count_o saturated at 8'hFF.

Source files
------------

// File: rtl/audio_packet_rx.sv
// Audio packet receiver: pulls bytes from an input FIFO, parses SYNC/CMD/LEN framed packets
// and presents 24-bit stereo frames over a valid/ready handshake.
module audio_packet_rx #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] CMD_AUDIO = 8'h01
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        rd_in_fifo_clk_o,
   output logic        rd_in_fifo_en_o,
   input  logic        rd_in_fifo_empty_i,
   input  logic [7:0]  rd_in_fifo_data_i,
   output logic        sample_valid_o,
   input  logic        sample_ready_i,
   output logic [23:0] sample_left_o,
   output logic [23:0] sample_right_o,
   output logic        rate_48k_o,
   output logic        pkt_err_o,
   output logic [7:0]  err_count_o
);

   typedef enum logic [2:0] {StSync, StCmd, StLen, StData, StOut} state_e;

   state_e      state_q;
   logic        rd_en_q;
   logic        cap_q;
   logic        pend_rate_q;
   logic [7:0]  frame_cnt_q;
   logic [2:0]  idx_q;
   logic [39:0] asm_q;
   logic        valid_q;
   logic [23:0] left_q;
   logic [23:0] right_q;
   logic        rate_q;
   logic        pkt_err_q;
   logic [7:0]  err_count_q;
   logic        last_byte;

   // The capture that completes a frame moves us into OUT, so no new read may be issued with it.
   assign last_byte = cap_q && (state_q == StData) && (idx_q == 3'd5);

   assign rd_in_fifo_clk_o = clk_i;
   assign rd_in_fifo_en_o  = rd_en_q;
   assign sample_valid_o   = valid_q;
   assign sample_left_o    = left_q;
   assign sample_right_o   = right_q;
   assign rate_48k_o       = rate_q;
   assign pkt_err_o        = pkt_err_q;
   assign err_count_o      = err_count_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StSync;
         rd_en_q     <= 1'b0;
         cap_q       <= 1'b0;
         pend_rate_q <= 1'b0;
         frame_cnt_q <= 8'd0;
         idx_q       <= 3'd0;
         asm_q       <= 40'd0;
         valid_q     <= 1'b0;
         left_q      <= 24'd0;
         right_q     <= 24'd0;
         rate_q      <= 1'b0;
         pkt_err_q   <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         rd_en_q   <= !rd_en_q && !rd_in_fifo_empty_i && (state_q != StOut) && !last_byte;
         cap_q     <= rd_en_q;
         pkt_err_q <= 1'b0;
         if (pkt_err_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end
         case (state_q)
            StSync: begin
               if (cap_q && (rd_in_fifo_data_i == SYNC_BYTE)) begin
                  state_q <= StCmd;
               end
            end
            StCmd: begin
               if (cap_q) begin
                  if (rd_in_fifo_data_i[6:0] == CMD_AUDIO[6:0]) begin
                     pend_rate_q <= rd_in_fifo_data_i[7];
                     state_q     <= StLen;
                  end else begin
                     pkt_err_q <= 1'b1;
                     state_q   <= StSync;
                  end
               end
            end
            StLen: begin
               if (cap_q) begin
                  if (rd_in_fifo_data_i == 8'd0) begin
                     pkt_err_q <= 1'b1;
                     state_q   <= StSync;
                  end else begin
                     frame_cnt_q <= rd_in_fifo_data_i;
                     idx_q       <= 3'd0;
                     state_q     <= StData;
                  end
               end
            end
            StData: begin
               if (cap_q) begin
                  if (idx_q == 3'd5) begin
                     // Sixth byte goes straight to the output; bytes 0..4 sit in asm_q.
                     left_q  <= asm_q[23:0];
                     right_q <= {rd_in_fifo_data_i, asm_q[39:24]};
                     rate_q  <= pend_rate_q;
                     valid_q <= 1'b1;
                     state_q <= StOut;
                  end else begin
                     asm_q <= {rd_in_fifo_data_i, asm_q[39:8]};
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            StOut: begin
               if (valid_q && sample_ready_i) begin
                  valid_q     <= 1'b0;
                  frame_cnt_q <= frame_cnt_q - 8'd1;
                  idx_q       <= 3'd0;
                  state_q     <= (frame_cnt_q == 8'd1) ? StSync : StData;
               end
            end
            default: state_q <= StSync;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_packet_rx.sv
// Scoreboard bench for audio_packet_rx: a byte-queue FIFO model feeds directed packets and a
// monitor compares every accepted frame against the expected-frame queue.
module tb_audio_packet_rx;

   typedef struct packed {
      logic [23:0] l;
      logic [23:0] r;
      logic        rate;
   } frame_t;

   logic        clk;
   logic        reset_i;
   logic        rd_clk;
   logic        rd_en;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        valid;
   logic        ready;
   logic [23:0] left;
   logic [23:0] right;
   logic        rate;
   logic        pkt_err;
   logic [7:0]  err_count;

   logic [7:0] fifo_q[$];
   int         fifo_cnt = 0;
   logic       pop_pending = 1'b0;
   logic [7:0] pop_byte = 8'h00;
   frame_t     exp_q[$];
   int         n_total = 0;
   int         n_pass = 0;
   int         err_pulses = 0;

   audio_packet_rx dut (
      .clk_i              (clk),
      .reset_i            (reset_i),
      .rd_in_fifo_clk_o   (rd_clk),
      .rd_in_fifo_en_o    (rd_en),
      .rd_in_fifo_empty_i (fifo_empty),
      .rd_in_fifo_data_i  (fifo_data),
      .sample_valid_o     (valid),
      .sample_ready_i     (ready),
      .sample_left_o      (left),
      .sample_right_o     (right),
      .rate_48k_o         (rate),
      .pkt_err_o          (pkt_err),
      .err_count_o        (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = (fifo_cnt == 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      fifo_cnt++;
   endtask

   // FIFO model: strobe seen mid-cycle, data presented from the next rising edge.
   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         chk("rd_nonempty", {31'd0, fifo_cnt != 0}, 32'd1);
         if (fifo_cnt != 0) begin
            pop_byte = fifo_q.pop_front();
            fifo_cnt--;
            pop_pending = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (pop_pending) begin
         fifo_data <= pop_byte;
         pop_pending = 1'b0;
      end
   end

   // Monitor: compare each frame on its accepting cycle.
   always @(negedge clk) begin
      if (reset_i === 1'b0) begin
         if (pkt_err === 1'b1) err_pulses++;
         if (valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", {31'd0, valid}, 32'd0);
            end else begin
               frame_t e;
               e = exp_q.pop_front();
               chk("left", {8'd0, left}, {8'd0, e.l});
               chk("right", {8'd0, right}, {8'd0, e.r});
               chk("rate", {31'd0, rate}, {31'd0, e.rate});
            end
         end
      end
   end

   task automatic drain(input int budget);
      int done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fifo_cnt == 0 && exp_q.size() == 0) begin
            done = 1;
            break;
         end
      end
      chk("drain_timeout", done, 1);
      repeat (6) @(negedge clk);
   endtask

   task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
      push(l[7:0]); push(l[15:8]); push(l[23:16]);
      push(r[7:0]); push(r[15:8]); push(r[23:16]);
   endtask

   initial begin
      int seen;
      fifo_data = 8'h00;
      reset_i   = 1'b1;
      ready     = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
      chk("rst_left", {8'd0, left}, 32'd0);
      chk("rst_right", {8'd0, right}, 32'd0);
      chk("rst_rate", {31'd0, rate}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      reset_i = 1'b0;

      // Two 48k frames, with an empty-FIFO stall mid-packet.
      push(8'hA5); push(8'h81); push(8'h02);
      push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05); push(8'h06);
      exp_q.push_back('{l: 24'h030201, r: 24'h060504, rate: 1'b1});
      exp_q.push_back('{l: 24'h7FFFFF, r: 24'h800000, rate: 1'b1});
      repeat (30) @(negedge clk);
      push(8'hFF); push(8'hFF); push(8'h7F); push(8'h00); push(8'h00); push(8'h80);
      drain(500);
      chk("a_err_count", {24'd0, err_count}, 32'd0);
      chk("a_err_pulses", err_pulses, 0);

      // Silent resync on leading garbage, 44.1k family.
      push(8'h00); push(8'h13); push(8'hA5); push(8'h01); push(8'h01);
      push_frame(24'h332211, 24'h665544);
      exp_q.push_back('{l: 24'h332211, r: 24'h665544, rate: 1'b0});
      drain(500);
      chk("b_err_count", {24'd0, err_count}, 32'd0);
      chk("b_err_pulses", err_pulses, 0);

      // Bad CMD and zero LEN.
      push(8'hA5); push(8'h02);
      push(8'hA5); push(8'h01); push(8'h00);
      drain(500);
      chk("c_err_count", {24'd0, err_count}, 32'd2);
      chk("c_err_pulses", err_pulses, 2);

      // Backpressure: frame held for 20 cycles while more bytes wait in the FIFO.
      ready = 1'b0;
      push(8'hA5); push(8'h81); push(8'h01);
      push_frame(24'h302010, 24'h605040);
      exp_q.push_back('{l: 24'h302010, r: 24'h605040, rate: 1'b1});
      push(8'hA5); push(8'h01); push(8'h01);
      push_frame(24'h0A0B0C, 24'hF0E0D0);
      exp_q.push_back('{l: 24'h0A0B0C, r: 24'hF0E0D0, rate: 1'b0});
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("stall_valid_seen", seen, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, valid}, 32'd1);
         chk("stall_left", {8'd0, left}, 32'h00302010);
         chk("stall_right", {8'd0, right}, 32'h00605040);
         chk("stall_rd_en", {31'd0, rd_en}, 32'd0);
      end
      @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 chk("accept_first_ready", {31'd0, valid}, 32'd0);
      drain(500);
      chk("d_err_count", {24'd0, err_count}, 32'd2);

      // Reset in the middle of a frame; only the following packet may appear.
      push(8'hA5); push(8'h81); push(8'h01); push(8'h01); push(8'h02); push(8'h03);
      drain(500);
      reset_i = 1'b1;
      repeat (2) @(negedge clk);
      err_pulses = 0;
      reset_i    = 1'b0;
      chk("e_rst_err_count", {24'd0, err_count}, 32'd0);
      push(8'hA5); push(8'h01); push(8'h01);
      push_frame(24'hCCBBAA, 24'hFFEEDD);
      exp_q.push_back('{l: 24'hCCBBAA, r: 24'hFFEEDD, rate: 1'b0});
      drain(500);
      chk("e_err_count", {24'd0, err_count}, 32'd0);
      chk("e_err_pulses", err_pulses, 0);

      // Error counter saturation.
      for (int i = 0; i < 300; i++) begin
         push(8'hA5);
         push(8'h02);
      end
      drain(5000);
      chk("f_err_count_sat", {24'd0, err_count}, 32'h000000FF);
      chk("f_err_pulses", err_pulses, 300);
      chk("f_no_valid", {31'd0, valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
